// File: rtl/uart_tx_block.sv
// uart_tx_block: 8N1 UART transmitter that streams one fixed-size block
// of bytes out of a synchronous-read byte RAM.
// - A start request fetches bytes 0..NUM_PACKETS-1 in order.
// - Each byte is sent LSB first.
// - packet_en pulses when a byte's stop bit completes.
// - buffer_finish pulses with the final byte's packet_en.
module uart_tx_block #(
  parameter int CLK_FREQ    = 12_000_000,
  parameter int BAUD        = 115_200,
  parameter int NUM_PACKETS = 256,
  localparam int ADDR_BITS  = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  output logic                 busy,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [7:0]           rd_data,
  output logic                 packet_en,
  output logic [ADDR_BITS-1:0] packet_count,
  output logic                 buffer_finish,
  output logic                 tx
);

  // Clock cycles per serial bit.
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  // The baud counter only has to reach CLKS_PER_BIT-1.
  localparam int CNT_BITS = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_BITS-1:0]  BAUD_LAST = CNT_BITS'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_PACKETS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_START_BIT,
    S_DATA,
    S_STOP_BIT
  } state_t;

  state_t                 state_reg,    state_next;
  logic [CNT_BITS-1:0]    baud_cnt_reg, baud_cnt_next;
  logic [2:0]             bit_idx_reg,  bit_idx_next;
  logic [7:0]             data_reg,     data_next;
  logic [ADDR_BITS-1:0]   rd_addr_reg,  rd_addr_next;
  logic                   busy_reg,     busy_next;
  logic                   tx_reg,       tx_next;

  logic baud_last;
  logic last_byte;

  // End of the current bit period.
  assign baud_last = (baud_cnt_reg == BAUD_LAST);

  // Marks the final byte of the block.
  // The address increment is gated on it, so the address never wraps.
  assign last_byte = (rd_addr_reg == LAST_ADDR);

  assign busy         = busy_reg;
  assign rd_addr      = rd_addr_reg;
  assign packet_count = rd_addr_reg;
  assign tx           = tx_reg;

  // State and datapath registers.
  // The asynchronous reset forces tx high immediately, even mid-frame.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg    <= S_IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      data_reg     <= '0;
      rd_addr_reg  <= '0;
      busy_reg     <= 1'b0;
      tx_reg       <= 1'b1;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      data_reg     <= data_next;
      rd_addr_reg  <= rd_addr_next;
      busy_reg     <= busy_next;
      tx_reg       <= tx_next;
    end
  end

  // Next-state logic and the per-byte strobes.
  // The line level is derived from the state being entered,
  // so tx is always registered.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg;
    bit_idx_next  = bit_idx_reg;
    data_next     = data_reg;
    rd_addr_next  = rd_addr_reg;
    busy_next     = busy_reg;
    packet_en     = 1'b0;
    buffer_finish = 1'b0;
    tx_next       = 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          rd_addr_next = '0;
          busy_next    = 1'b1;
          state_next   = S_FETCH;
        end
      end

      // The RAM samples rd_addr during this cycle.
      S_FETCH: begin
        state_next = S_LOAD;
      end

      // RAM output is valid now; capture it and start the bit timer.
      S_LOAD: begin
        data_next     = rd_data;
        baud_cnt_next = '0;
        state_next    = S_START_BIT;
      end

      S_START_BIT: begin
        if (baud_last) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = S_DATA;
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_last) begin
          baud_cnt_next = '0;
          data_next     = {1'b0, data_reg[7:1]};
          if (bit_idx_reg == 3'd7) begin
            state_next = S_STOP_BIT;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      S_STOP_BIT: begin
        if (baud_last) begin
          baud_cnt_next = '0;
          packet_en     = 1'b1;
          if (last_byte) begin
            buffer_finish = 1'b1;
            busy_next     = 1'b0;
            state_next    = S_IDLE;
          end else begin
            rd_addr_next = rd_addr_reg + ADDR_BITS'(1);
            state_next   = S_FETCH;
          end
        end else begin
          baud_cnt_next = baud_cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase

    case (state_next)
      S_START_BIT: tx_next = 1'b0;
      S_DATA:      tx_next = data_next[0];
      default:     tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_block.sv
// Scoreboard bench for uart_tx_block.
// - DUT A: 4-byte block. DUT B: single-byte block.
// - Expected frames and packet indices are queued when a block is launched.
// - Monitor processes decode tx and the packet_en strobes, then compare.
module tb_uart_tx_block;

  localparam int CLK_FREQ = 12_000_000;
  localparam int BAUD     = 3_000_000;
  localparam int CPB      = 4;
  localparam int NP_A     = 4;
  localparam int NP_B     = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       n_rst;
  logic       start_a, start_b;
  logic       busy_a, busy_b;
  logic [1:0] rd_addr_a, pc_a;
  logic [0:0] rd_addr_b, pc_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       pe_a, pe_b, bf_a, bf_b, tx_a, tx_b;

  logic [7:0] ram_a [NP_A];
  logic [7:0] ram_b [NP_B];

  uart_tx_block #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NUM_PACKETS(NP_A)) dut_a (
    .clk(clk), .n_rst(n_rst), .start(start_a), .busy(busy_a),
    .rd_addr(rd_addr_a), .rd_data(rd_data_a), .packet_en(pe_a),
    .packet_count(pc_a), .buffer_finish(bf_a), .tx(tx_a)
  );

  uart_tx_block #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .NUM_PACKETS(NP_B)) dut_b (
    .clk(clk), .n_rst(n_rst), .start(start_b), .busy(busy_b),
    .rd_addr(rd_addr_b), .rd_data(rd_data_b), .packet_en(pe_b),
    .packet_count(pc_b), .buffer_finish(bf_b), .tx(tx_b)
  );

  // Synchronous-read RAM models
  always @(posedge clk) rd_data_a <= ram_a[rd_addr_a];
  always @(posedge clk) rd_data_b <= ram_b[rd_addr_b];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    bit         first;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   idx_q_a[$];
  int   idx_q_b[$];
  int   pe_cnt_a = 0;
  int   pe_cnt_b = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string msg);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", msg, cyc);
  endtask

  function automatic logic sel_tx(input bit is_b);
    return is_b ? tx_b : tx_a;
  endfunction

  // Serial decoder.
  // Samples every clock of a 10-bit frame and requires each bit to hold
  // for CPB clocks. The frame is then compared with the next expected byte.
  task automatic decode(input bit is_b);
    logic [9:0] raw;
    logic       cur;
    bit         stable, aborted;
    int         fall, prev_fall;
    exp_t       e;
    string      tag;
    tag = is_b ? "B" : "A";
    prev_fall = 0;
    forever begin
      @(negedge clk);
      if (n_rst === 1'b1 && sel_tx(is_b) === 1'b0) begin
        fall    = cyc;
        stable  = 1;
        aborted = 0;
        raw     = '0;
        for (int b = 0; b < 10 && !aborted; b++) begin
          for (int k = 0; k < CPB && !aborted; k++) begin
            if (!(b == 0 && k == 0)) @(negedge clk);
            if (n_rst !== 1'b1) begin
              aborted = 1;
            end else begin
              cur = sel_tx(is_b);
              if (k == 0) raw[b] = cur;
              else if (cur !== raw[b]) stable = 0;
            end
          end
        end
        if (!aborted) begin
          if ((is_b ? q_b.size() : q_a.size()) == 0) begin
            fail({"unexpected_frame_", tag});
          end else begin
            e = is_b ? q_b.pop_front() : q_a.pop_front();
            check({"frame_bits_", tag}, 32'(raw), 32'({1'b1, e.data, 1'b0}));
            check({"bit_stable_", tag}, 32'(stable), 32'd1);
            if (!e.first) check({"frame_gap_", tag}, 32'(fall - prev_fall), 32'd42);
            $display("frame %s: byte 0x%02h at cycle %0d", tag, raw[8:1], fall);
          end
          prev_fall = fall;
        end
      end
    end
  endtask

  // packet_en / buffer_finish monitor.
  task automatic strobe_mon(input bit is_b);
    int    i, last;
    logic  pe, bf;
    logic [31:0] pc;
    string tag;
    tag  = is_b ? "B" : "A";
    last = is_b ? NP_B - 1 : NP_A - 1;
    forever begin
      @(negedge clk);
      pe = is_b ? pe_b : pe_a;
      bf = is_b ? bf_b : bf_a;
      pc = is_b ? 32'(pc_b) : 32'(pc_a);
      if (pe) begin
        if (is_b) pe_cnt_b++; else pe_cnt_a++;
        if ((is_b ? idx_q_b.size() : idx_q_a.size()) == 0) begin
          fail({"unexpected_packet_en_", tag});
        end else begin
          i = is_b ? idx_q_b.pop_front() : idx_q_a.pop_front();
          check({"packet_count_", tag}, pc, 32'(i));
          check({"finish_on_last_", tag}, 32'(bf), 32'(i == last));
        end
      end else if (bf) begin
        fail({"finish_without_packet_en_", tag});
      end
    end
  endtask

  initial decode(1'b0);
  initial decode(1'b1);
  initial strobe_mon(1'b0);
  initial strobe_mon(1'b1);

  // Queue a whole block for DUT A, pulse start and measure start-to-tx-low.
  task automatic launch_a(input string tag);
    exp_t e;
    int   lat;
    for (int i = 0; i < NP_A; i++) begin
      e.data  = ram_a[i];
      e.first = (i == 0);
      q_a.push_back(e);
      idx_q_a.push_back(i);
    end
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check({tag, "_busy_after_start"}, 32'(busy_a), 32'd1);
    check({tag, "_addr_after_start"}, 32'(rd_addr_a), 32'd0);
    lat = 1;
    while (tx_a === 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_start_latency"}, 32'(lat), 32'd3);
  endtask

  // Wait for buffer_finish on A; optionally keep poking start while busy.
  task automatic wait_finish_a(input bit poke, output bit seen);
    seen = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (bf_a === 1'b1) begin
        seen = 1;
        break;
      end
      if (poke && (k % 5 == 0)) start_a = 1'b1;
    end
    if (!seen) fail("timeout_buffer_finish_A");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int pe_before;
    n_rst   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ram_a[0] = 8'h55; ram_a[1] = 8'h00; ram_a[2] = 8'hFF; ram_a[3] = 8'hA3;
    ram_b[0] = 8'h3C;
    repeat (3) @(negedge clk);

    check("reset_tx_A", 32'(tx_a), 32'd1);
    check("reset_busy_A", 32'(busy_a), 32'd0);
    check("reset_addr_A", 32'(rd_addr_a), 32'd0);
    check("reset_pe_A", 32'(pe_a), 32'd0);
    check("reset_bf_A", 32'(bf_a), 32'd0);
    check("reset_tx_B", 32'(tx_b), 32'd1);
    check("reset_busy_B", 32'(busy_b), 32'd0);
    n_rst = 1'b1;
    @(negedge clk);

    // Block 1: start is poked repeatedly while busy and must be ignored.
    pe_before = pe_cnt_a;
    launch_a("blk1");
    wait_finish_a(1'b1, seen);
    check("blk1_pe_with_finish", 32'(pe_a), 32'd1);
    check("blk1_addr_at_finish", 32'(rd_addr_a), 32'd3);
    start_a = 1'b1;                 // same cycle as buffer_finish: ignored
    @(negedge clk);
    start_a = 1'b0;
    check("blk1_busy_after_finish", 32'(busy_a), 32'd0);
    check("blk1_addr_holds", 32'(rd_addr_a), 32'd3);
    check("blk1_packet_en_count", 32'(pe_cnt_a - pe_before), 32'd4);

    // Block 2: start in the cycle after buffer_finish; reset mid-DATA of byte 2.
    launch_a("blk2");
    seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk);
      if (rd_addr_a == 2'd2) seen = 1;
    end
    if (!seen) fail("timeout_byte2_A");
    repeat (10) @(negedge clk);
    check("blk2_busy_before_reset", 32'(busy_a), 32'd1);
    pe_before = pe_cnt_a;
    #2;
    n_rst = 1'b0;
    q_a.delete();
    idx_q_a.delete();
    #1;
    check("rst_mid_tx_A", 32'(tx_a), 32'd1);
    check("rst_mid_busy_A", 32'(busy_a), 32'd0);
    check("rst_mid_addr_A", 32'(rd_addr_a), 32'd0);
    check("rst_mid_pe_A", 32'(pe_a), 32'd0);
    check("rst_mid_bf_A", 32'(bf_a), 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("rst_no_packet_en", 32'(pe_cnt_a - pe_before), 32'd0);

    // Block 3: full resend from byte 0 after the reset.
    pe_before = pe_cnt_a;
    launch_a("blk3");
    wait_finish_a(1'b0, seen);
    @(negedge clk);
    check("blk3_busy_after_finish", 32'(busy_a), 32'd0);
    check("blk3_packet_en_count", 32'(pe_cnt_a - pe_before), 32'd4);
    @(negedge clk);
    check("A_frames_left", 32'(q_a.size()), 32'd0);
    check("A_indices_left", 32'(idx_q_a.size()), 32'd0);

    // Single-byte block on DUT B.
    begin
      exp_t e;
      e.data  = ram_b[0];
      e.first = 1;
      q_b.push_back(e);
      idx_q_b.push_back(0);
    end
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("B_busy_after_start", 32'(busy_b), 32'd1);
    seen = 0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(negedge clk);
      if (bf_b === 1'b1) seen = 1;
    end
    if (!seen) fail("timeout_buffer_finish_B");
    check("B_pe_with_finish", 32'(pe_b), 32'd1);
    check("B_addr_at_finish", 32'(rd_addr_b), 32'd0);
    @(negedge clk);
    check("B_busy_after_finish", 32'(busy_b), 32'd0);
    check("B_addr_after_finish", 32'(rd_addr_b), 32'd0);
    check("B_packet_en_count", 32'(pe_cnt_b), 32'd1);
    @(negedge clk);
    check("B_frames_left", 32'(q_b.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
